// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared constants and the scan FSM state type for the 32x32
//             HUB75 panel scan sequencer (led_scan_ctrl and scan_timer).
//  Contents : panel geometry, pixel layout offsets, derived counter widths,
//             scan_state_t enumeration.
//  Revision : 1.0  initial release
// ============================================================================
package led_pkg;

    // Panel geometry and colour depth
    localparam int NCOLS    = 32;   // columns shifted per row
    localparam int NROWADDR = 16;   // row-pair addresses on a..d
    localparam int NBITS    = 3;    // bit-planes per colour
    localparam int ON_BASE  = 64;   // oe_n-low cycles of plane 0

    // Pixel layout: {r[2:0], g[2:0], b[2:0]}
    localparam int PIX_W = 9;
    localparam int R_OFS = 6;
    localparam int G_OFS = 3;
    localparam int B_OFS = 0;

    // Derived widths
    localparam int COL_W   = $clog2(NCOLS);
    localparam int ROW_W   = $clog2(NROWADDR);
    localparam int PLANE_W = $clog2(NBITS);
    localparam int ON_MAX  = ON_BASE << (NBITS - 1);
    localparam int ON_W    = $clog2(ON_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } scan_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_scan_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Loadable down-counter timing the DISPLAY (oe_n low) interval.
//             Loading V gives V+1 cycles until and including the done cycle.
//  Ports    : clk      - system clock
//             rst_n    - asynchronous active-low reset
//             i_load   - load i_value into the counter
//             i_value  - reload value (interval length minus one)
//             o_done   - counter has reached zero
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule : scan_timer
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_scan_ctrl
//  Purpose  : HUB75 scan sequencer for a 32x32 panel. Reads pixel pairs from
//             the double-buffered frame RAM, shifts one bit-plane per row
//             pair, latches, then enables the LEDs for a binary-weighted time
//             (bit-angle modulation). Owns the front/back buffer swap.
//  Ports    : clk, reset (async, active low)
//             en        - run enable, sampled at frame boundaries only
//             swap_req  - writer has filled the back buffer (level)
//             swap_ack  - one-cycle pulse when the swap is taken
//             buf_sel   - buffer currently displayed
//             rd_addr   - {buf_sel, row, col} frame RAM read address
//             rd_data   - {top pixel, bottom pixel}, valid 1 cycle after addr
//             r0..b1    - serial colour bits, outclk/latch/oe_n - panel ctrl
//             a..d      - row address (a = LSB)
//             bright    - (LED_SCAN_BRIGHT_EN only) global brightness 0..7
//  Options  : `define LED_SCAN_BRIGHT_EN adds the bright[2:0] input.
//  Revision : 1.0  initial release
// ============================================================================
module led_scan_ctrl
    import led_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        swap_req,
`ifdef LED_SCAN_BRIGHT_EN
    input  logic [2:0]  bright,
`endif
    output logic        swap_ack,
    output logic        buf_sel,
    output logic [9:0]  rd_addr,
    input  logic [17:0] rd_data,
    output logic        r0,
    output logic        g0,
    output logic        b0,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        outclk,
    output logic        latch,
    output logic        oe_n,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d
);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NCOLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NROWADDR - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(NBITS - 1);

    scan_state_t        r_state;
    scan_state_t        w_next;
    logic [ROW_W-1:0]   r_row;
    logic [PLANE_W-1:0] r_plane;
    logic [COL_W-1:0]   r_col;
    logic [1:0]         r_ph;
    logic               r_buf_sel;
    logic               r_swap_ack;
    logic               r_outclk;
    logic [5:0]         r_rgb;       // {r0, g0, b0, r1, g1, b1}
    logic [ROW_W-1:0]   r_rowaddr;

    logic               w_load;
    logic               w_timer_done;
    logic               w_last_disp;
    logic               w_frame_end;
    logic [ON_W-1:0]    w_len_m1;

    // ------------------------------------------------------------------
    // DISPLAY length for the current plane (loaded during LATCH)
    // ------------------------------------------------------------------
`ifdef LED_SCAN_BRIGHT_EN
    logic [2:0] r_bright;
    int         w_len;

    // Brightness is frozen for a whole frame so planes stay consistent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bright <= 3'd7;
        end else if (en && ((r_state == ST_IDLE) || w_frame_end)) begin
            r_bright <= bright;
        end
    end

    always_comb begin
        w_len = ((ON_BASE << r_plane) * (int'(r_bright) + 1)) / 8;
        if (w_len < 1) begin
            w_len = 1;
        end
        w_len_m1 = ON_W'(w_len - 1);
    end
`else
    assign w_len_m1 = ON_W'((ON_BASE << r_plane) - 1);
`endif

    scan_timer #(
        .WIDTH   (ON_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_value (w_len_m1),
        .o_done  (w_timer_done)
    );

    assign w_last_disp = (r_state == ST_DISPLAY) && w_timer_done;
    assign w_frame_end = w_last_disp && (r_row == ROW_LAST) && (r_plane == PLANE_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if ((r_ph == 2'd3) && (r_col == COL_LAST)) begin
                    w_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                w_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_next = ST_DISPLAY;
                w_load = 1'b1;
            end
            ST_DISPLAY: begin
                if (w_last_disp) begin
                    if (w_frame_end && !en) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_SHIFT;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and scan datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_plane    <= '0;
            r_col      <= '0;
            r_ph       <= '0;
            r_buf_sel  <= 1'b0;
            r_swap_ack <= 1'b0;
            r_outclk   <= 1'b0;
            r_rgb      <= '0;
            r_rowaddr  <= '0;
        end else begin
            r_state    <= w_next;
            r_swap_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_row   <= '0;
                        r_plane <= '0;
                        r_col   <= '0;
                        r_ph    <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_ph <= r_ph + 2'd1;
                    case (r_ph)
                        // RAM answers the ph0 address during ph1
                        2'd1: r_rgb <= {rd_data[PIX_W + R_OFS + int'(r_plane)],
                                        rd_data[PIX_W + G_OFS + int'(r_plane)],
                                        rd_data[PIX_W + B_OFS + int'(r_plane)],
                                        rd_data[R_OFS + int'(r_plane)],
                                        rd_data[G_OFS + int'(r_plane)],
                                        rd_data[B_OFS + int'(r_plane)]};
                        2'd2: r_outclk <= 1'b1;
                        2'd3: begin
                            r_outclk <= 1'b0;
                            r_col    <= r_col + COL_W'(1);   // wraps to 0 after last column
                        end
                        default: ;
                    endcase
                end
                ST_BLANK: begin
                    r_rowaddr <= r_row;
                end
                ST_DISPLAY: begin
                    if (w_timer_done) begin
                        if (r_plane == PLANE_LAST) begin
                            r_plane <= '0;
                            r_row   <= r_row + ROW_W'(1);    // wraps modulo NROWADDR
                        end else begin
                            r_plane <= r_plane + PLANE_W'(1);
                        end
                        // Swap only between frames so a frame never mixes buffers
                        if (w_frame_end && swap_req) begin
                            r_buf_sel  <= ~r_buf_sel;
                            r_swap_ack <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. oe_n and latch decode the state directly so that an
    // asynchronous reset blanks the panel without waiting for a clock.
    // ------------------------------------------------------------------
    assign oe_n     = (r_state != ST_DISPLAY);
    assign latch    = (r_state == ST_LATCH);
    assign outclk   = r_outclk;
    assign swap_ack = r_swap_ack;
    assign buf_sel  = r_buf_sel;
    assign rd_addr  = {r_buf_sel, r_row, r_col};
    assign {r0, g0, b0, r1, g1, b1} = r_rgb;
    assign {d, c, b, a} = r_rowaddr;

endmodule : led_scan_ctrl
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_scan_ctrl
//  Purpose  : Scoreboard bench for led_scan_ctrl. The stimulus process queues
//             the expected (row, plane, on-time, colour, buffer) of every slot
//             and the expected swaps; a monitor pops them as the DUT latches
//             rows, ends oe_n pulses and acknowledges swaps.
//  Options  : LED_SCAN_BRIGHT_EN connects bright = 3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_scan_ctrl;

`ifdef LED_SCAN_BRIGHT_EN
    localparam int LEN0  = 32;
    localparam int LEN1  = 64;
    localparam int LEN2  = 128;
    localparam int FRAME = 9824;    // 16 * (3*130 + 224)
`else
    localparam int LEN0  = 64;
    localparam int LEN1  = 128;
    localparam int LEN2  = 256;
    localparam int FRAME = 13408;   // 16 * (3*130 + 448)
`endif
    localparam int NCOL = 32;

    typedef struct {
        int         row;
        int         plane;
        int         len;
        logic [5:0] rgb;
        logic       bsel;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        swap_req;
    logic        swap_ack;
    logic        buf_sel;
    logic [9:0]  rd_addr;
    logic [17:0] rd_data = '0;
    logic        r0, g0, b0, r1, g1, b1;
    logic        outclk, latch, oe_n;
    logic        a, b, c, d;
`ifdef LED_SCAN_BRIGHT_EN
    logic [2:0]  bright = 3'd3;
`endif

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    logic  mon_en = 1'b0;
    slot_t sq[$];
    logic  swq[$];

    always #5 clk = ~clk;

    // Frame RAM: buffer 0 = top red MSB set, buffer 1 = bottom blue all set
    always @(posedge clk) rd_data <= rd_addr[9] ? 18'h00007 : 18'h20000;

    led_scan_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .swap_req (swap_req),
`ifdef LED_SCAN_BRIGHT_EN
        .bright   (bright),
`endif
        .swap_ack (swap_ack),
        .buf_sel  (buf_sel),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .r0       (r0),
        .g0       (g0),
        .b0       (b0),
        .r1       (r1),
        .g1       (g1),
        .b1       (b1),
        .outclk   (outclk),
        .latch    (latch),
        .oe_n     (oe_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        slot_t cur;
        int    edge_cnt = 0;
        int    col_bad  = 0;
        int    addr_bad = 0;
        int    low_cnt  = 0;
        int    last_f   = -1;
        logic  p_outclk = 1'b0;
        logic  p_oe_n   = 1'b1;
        logic  p_buf    = 1'b0;
        logic  exp_b;
        cur = '{row: 0, plane: 0, len: 0, rgb: 6'd0, bsel: 1'b0};
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (outclk && !p_outclk) begin
                    edge_cnt++;
                    if (sq.size() > 0) begin
                        if ({r0, g0, b0, r1, g1, b1} != sq[0].rgb) col_bad++;
                        if (rd_addr[9] != sq[0].bsel) addr_bad++;
                    end
                end
                if (latch) begin
                    if (sq.size() == 0) begin
                        check("unexpected_latch", 1, 0);
                    end else begin
                        cur = sq.pop_front();
                        check("outclk_pulses", edge_cnt, NCOL);
                        check("colour_bits", col_bad, 0);
                        check("rd_addr_buf", addr_bad, 0);
                        check("row_addr", int'({d, c, b, a}), cur.row);
                        if (cur.row == 0 && cur.plane == 0) begin
                            if (last_f >= 0) check("frame_period", cyc - last_f, FRAME);
                            last_f = cyc;
                        end
                    end
                    edge_cnt = 0;
                    col_bad  = 0;
                    addr_bad = 0;
                end
                if (!oe_n) begin
                    low_cnt++;
                end else if (!p_oe_n) begin
                    check("oe_low_len", low_cnt, cur.len);
                    low_cnt = 0;
                end
                if (swap_ack) begin
                    if (swq.size() == 0) begin
                        check("unexpected_swap_ack", 1, 0);
                    end else begin
                        exp_b = swq.pop_front();
                        check("buf_sel_after_swap", int'(buf_sel), int'(exp_b));
                        check("buf_sel_toggled_with_ack", int'(buf_sel != p_buf), 1);
                        // ack is seen in the first cycle after the frame-end cycle
                        check("swap_cycle", cyc - last_f, FRAME - 129);
                    end
                end
            end
            p_outclk = outclk;
            p_oe_n   = oe_n;
            p_buf    = buf_sel;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        slot_t s;
        int    bad;
        int    n;
        int    lens[3];
        lens[0] = LEN0;
        lens[1] = LEN1;
        lens[2] = LEN2;
        reset    = 1'b0;
        en       = 1'b0;
        swap_req = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_oe_n", int'(oe_n), 1);
        check("rst_outclk", int'(outclk), 0);
        check("rst_latch", int'(latch), 0);
        check("rst_swap_ack", int'(swap_ack), 0);
        check("rst_buf_sel", int'(buf_sel), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_row_addr", int'({d, c, b, a}), 0);
        check("rst_colour", int'({r0, g0, b0, r1, g1, b1}), 0);

        // Released with en = 0: panel must stay dark and quiet
        reset = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!oe_n || outclk || latch) bad++;
        end
        check("idle_quiet", bad, 0);

        // Two frames: buffer 0 (r0 on plane 2 only), then buffer 1 (b1 always)
        for (int f = 0; f < 2; f++) begin
            for (int row = 0; row < 16; row++) begin
                for (int p = 0; p < 3; p++) begin
                    s.row   = row;
                    s.plane = p;
                    s.len   = lens[p];
                    s.rgb   = (f == 0) ? ((p == 2) ? 6'b100000 : 6'b000000) : 6'b000001;
                    s.bsel  = (f == 1);
                    sq.push_back(s);
                end
            end
        end
        mon_en = 1'b1;
        en     = 1'b1;

        repeat (500) @(negedge clk);
        swap_req = 1'b1;
        swq.push_back(1'b1);
        n = 0;
        while (!swap_ack && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("swap_ack_seen", int'(swap_ack), 1);
        @(negedge clk);
        swap_req = 1'b0;

        // Drop en mid-frame: the frame must still complete
        repeat (1000) @(negedge clk);
        en = 1'b0;
        n = 0;
        while ((sq.size() != 0) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("frame2_slots_left", sq.size(), 0);
        repeat (300) @(negedge clk);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!oe_n || outclk || latch) bad++;
        end
        check("idle_after_en_drop", bad, 0);
        check("swaps_outstanding", swq.size(), 0);
        check("buf_sel_final", int'(buf_sel), 1);

        // Asynchronous reset during DISPLAY
        mon_en = 1'b0;
        en     = 1'b1;
        n = 0;
        while (oe_n && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("display_reached", int'(oe_n), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_oe_n", int'(oe_n), 1);
        check("async_buf_sel", int'(buf_sel), 0);
        check("async_rd_addr", int'(rd_addr), 0);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_oe_n", int'(oe_n), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_led_scan_ctrl
`default_nettype wire

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Scan sequencer for the 32x32 HUB75-style panel.
- Reads 9-bit pixels (3 bits each of R, G, B) from the double-buffered frame RAM in the core, two pixels per read (top half and bottom half).
- Serialises one bit-plane per row pair onto r0..b1/outclk, then latches and blanks the panel.
- Drives the row address a..d and binary-weighted oe_n timing, so 3-bit colour is shown as bit-angle modulation.
- Owns the buffer-select/swap handshake between the SPI writer and the display.

Parameters:
- NCOLS, 32, columns shifted per row.
- NROWADDR, 16, row-pair addresses (a..d span).
- NBITS, 3, bit-planes per colour.
- ON_BASE, 64, oe_n-low cycles for plane 0; plane p lasts ON_BASE<<p.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  run enable; sampled only at frame boundaries.
- swap_req  in  1  level; writer has filled the back buffer.
- swap_ack  out  1  one-cycle pulse when the buffer swap is taken.
- buf_sel  out  1  buffer currently displayed.
- rd_addr  out  10  {buf_sel, row[3:0], col[4:0]} frame RAM read address.
- rd_data  in  18  [17:9] top pixel, [8:0] bottom pixel; each pixel is {r[2:0], g[2:0], b[2:0]}. Valid 1 cycle after rd_addr.
- r0, g0, b0, r1, g1, b1  out  1  serial colour bits for the current plane.
- outclk  out  1  panel shift clock.
- latch  out  1  panel latch strobe.
- oe_n  out  1  panel output enable, active low.
- a, b, c, d  out  1  row address, a = LSB.

Behaviour:
- Reset values:
  - FSM = IDLE; row = plane = col = 0; buf_sel = 0.
  - All colour outputs, outclk, latch, swap_ack, a..d, rd_addr = 0; oe_n = 1.
- FSM states: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - oe_n = 1.
  - If en = 1, go to SHIFT with row = 0, plane = 0, col = 0.
- SHIFT (oe_n = 1): each column takes 4 cycles, phase ph = 0..3.
  - ph0: drive rd_addr = {buf_sel, row, col}.
  - ph1: register colour outputs from rd_data:
    - r0 = rd_data[15+plane], g0 = rd_data[12+plane], b0 = rd_data[9+plane].
    - r1 = rd_data[6+plane], g1 = rd_data[3+plane], b1 = rd_data[plane].
  - ph2: outclk = 1.
  - ph3: outclk = 0; col++.
  - After ph3 of col = NCOLS-1, go to BLANK. SHIFT lasts exactly 4*NCOLS = 128 cycles.
- BLANK (1 cycle): oe_n = 1; a..d updated to row.
- LATCH (1 cycle): latch = 1, oe_n = 1.
- DISPLAY:
  - oe_n = 0 for exactly ON_BASE<<plane cycles; latch = 0; colour outputs hold.
  - At the last cycle, advance: plane++; on plane wrap, plane = 0 and row++. Row wraps modulo NROWADDR.
  - If not at a frame end, next state is SHIFT.
- Frame end = last DISPLAY cycle of row 15, plane 2. At frame end:
  - If swap_req = 1: toggle buf_sel and pulse swap_ack for the same single cycle.
  - If en = 1, go to SHIFT (row 0, plane 0); else go to IDLE.
- buf_sel never changes mid-frame. swap_req asserted mid-frame is acted on only at the next frame end.
- Timing per (row, plane) slot = 130 + ON_BASE<<plane cycles. Full frame = 16*(3*130 + 64*7) = 13408 cycles with defaults.
- en falling mid-frame is ignored; the current frame completes.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). oe_n goes 1 without waiting for clk.
- All counters are sized by $clog2 of their limit. No arithmetic overflow is permitted; the DISPLAY counter width covers ON_BASE<<(NBITS-1).

Optional Feature:
- LED_SCAN_BRIGHT_EN.
- Defined:
  - Adds input port bright[2:0].
  - DISPLAY length = (ON_BASE<<plane) * (bright+1) / 8, integer, minimum 1.
  - bright is sampled at frame start; value 7 reproduces the baseline timing.
- Undefined: no port; full-length DISPLAY only.

Decomposition:
- Package led_pkg holds:
  - scan_state_t enum.
  - Constants NCOLS, NROWADDR, NBITS, PIX_W = 9.
  - Bit offsets R_OFS = 6, G_OFS = 3, B_OFS = 0.
- One sub-module, scan_timer: loadable down-counter with a done flag, used for the DISPLAY duration. Everything else is inline.

Test Plan:
- Reset release with en = 0 -> oe_n stays 1 and outclk stays 0 for 1000 cycles.
- en = 1, RAM top pixel = 9'b100_000_000 everywhere, bottom = 0:
  - Row 0 plane 2: r0 = 1 on all 32 outclk rising edges.
  - Planes 0 and 1: r0 = 0.
  - 32 outclk pulses per SHIFT.
- Timing check:
  - Exactly one latch pulse per slot.
  - oe_n low lengths cycle 64, 128, 256.
  - a..d step 0..15 then wrap; frame period = 13408 cycles.
- swap_req raised at cycle 500 -> buf_sel toggles and swap_ack pulses once, both at cycle 13407 (frame end). rd_addr[9] = 1 from the next SHIFT onward.
- en dropped mid-frame -> the frame completes, then IDLE with oe_n = 1. Async reset asserted during DISPLAY -> oe_n = 1 before the next clk edge.
- LED_SCAN_BRIGHT_EN with bright = 3 -> oe_n low lengths are 32, 64, 128.
